// File: rtl/case_seq_monitor.sv
// case_seq_monitor
// Watches a decoded code stream and checks that it steps through 0, 1, .. LAST.
// Each code must be seen on HOLD valid samples before the next one is accepted.
// Any error ends the run and records its cause.
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high; forces IDLE and clears all outputs
//   start      - begins a run when not busy
//   in_valid   - qualifies in_value
//   in_value   - code from the upstream decode stage
//   busy       - a run is in progress
//   pass       - sticky: full sequence seen
//   fail       - sticky: run aborted
//   err_code   - 0 none, 1 unexpected value, 2 timeout, 3 early change
//   err_value  - in_value at the failing cycle (0 for a timeout)
//   expected   - code currently awaited
module case_seq_monitor #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned HOLD    = 2,
   parameter int unsigned LAST    = 2,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_value,
   output logic             busy,
   output logic             pass,
   output logic             fail,
   output logic [1:0]       err_code,
   output logic [WIDTH-1:0] err_value,
   output logic [WIDTH-1:0] expected
);

   localparam logic [3:0]       HoldCnt    = 4'(HOLD);
   localparam logic [7:0]       TimeoutCnt = 8'(TIMEOUT);
   localparam logic [WIDTH-1:0] LastCode   = WIDTH'(LAST);

   localparam logic [1:0] ErrNone       = 2'd0;
   localparam logic [1:0] ErrUnexpected = 2'd1;
   localparam logic [1:0] ErrTimeout    = 2'd2;
   localparam logic [1:0] ErrEarly      = 2'd3;

   typedef enum logic [1:0] {StIdle, StWait, StHold, StDone} state_e;

   state_e     r_state;
   logic [3:0] r_hold_cnt;
   logic [7:0] r_tmo_cnt;

   logic       w_match;
   logic       w_prev;
   logic       w_code_done;
   logic [3:0] w_hold_inc;
   logic [7:0] w_tmo_inc;

   always_comb begin
      w_match    = in_valid && (in_value == expected);
      // The previous code may still be on the bus right after a hand-over.
      w_prev     = in_valid && (expected != '0) && (in_value == expected - WIDTH'(1));
      w_hold_inc = r_hold_cnt + 4'd1;
      w_tmo_inc  = r_tmo_cnt + 8'd1;
      // A code completes on its HOLD-th matching sample; with HOLD==1 that is
      // the first match, seen while still in WAIT.
      w_code_done = 1'b0;
      if (r_state == StWait && w_match && HoldCnt == 4'd1) begin
         w_code_done = 1'b1;
      end else if (r_state == StHold && w_match && w_hold_inc == HoldCnt) begin
         w_code_done = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= StIdle;
         r_hold_cnt <= '0;
         r_tmo_cnt  <= '0;
         busy       <= 1'b0;
         pass       <= 1'b0;
         fail       <= 1'b0;
         err_code   <= ErrNone;
         err_value  <= '0;
         expected   <= '0;
      end else begin
         unique case (r_state)
            StIdle, StDone: begin
               if (start) begin
                  r_state    <= StWait;
                  r_hold_cnt <= '0;
                  r_tmo_cnt  <= '0;
                  busy       <= 1'b1;
                  pass       <= 1'b0;
                  fail       <= 1'b0;
                  err_code   <= ErrNone;
                  err_value  <= '0;
                  expected   <= '0;
               end
            end
            StWait, StHold: begin
               // Completion is checked first so a match always beats the timeout.
               if (w_code_done) begin
                  r_hold_cnt <= '0;
                  r_tmo_cnt  <= '0;
                  if (expected == LastCode) begin
                     r_state <= StDone;
                     busy    <= 1'b0;
                     pass    <= 1'b1;
                  end else begin
                     r_state  <= StWait;
                     expected <= expected + WIDTH'(1);
                  end
               end else if (r_state == StWait) begin
                  if (w_match) begin
                     r_state    <= StHold;
                     r_hold_cnt <= 4'd1;
                  end else if (in_valid && !w_prev) begin
                     r_state   <= StDone;
                     busy      <= 1'b0;
                     fail      <= 1'b1;
                     err_code  <= ErrUnexpected;
                     err_value <= in_value;
                  end else if (w_tmo_inc >= TimeoutCnt) begin
                     r_state   <= StDone;
                     busy      <= 1'b0;
                     fail      <= 1'b1;
                     err_code  <= ErrTimeout;
                     err_value <= '0;
                  end else begin
                     r_tmo_cnt <= w_tmo_inc;
                  end
               end else if (in_valid) begin
                  // In HOLD: a bubble freezes the count, a new value aborts.
                  if (w_match) begin
                     r_hold_cnt <= w_hold_inc;
                  end else begin
                     r_state   <= StDone;
                     busy      <= 1'b0;
                     fail      <= 1'b1;
                     err_code  <= ErrEarly;
                     err_value <= in_value;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_case_seq_monitor.sv
module tb_case_seq_monitor;

   logic       clk;
   logic       reset;
   logic       start;
   logic       in_valid;
   logic [3:0] in_value;
   logic       busy;
   logic       pass;
   logic       fail;
   logic [1:0] err_code;
   logic [3:0] err_value;
   logic [3:0] expected;

   typedef struct packed {
      logic       pass;
      logic       fail;
      logic [1:0] code;
      logic [3:0] val;
   } res_t;

   res_t sb_q[$];
   int   n_checks;
   int   n_pass;

   case_seq_monitor #(
      .WIDTH  (4),
      .HOLD   (2),
      .LAST   (2),
      .TIMEOUT(16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_valid (in_valid),
      .in_value (in_value),
      .busy     (busy),
      .pass     (pass),
      .fail     (fail),
      .err_code (err_code),
      .err_value(err_value),
      .expected (expected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled there too.
   task automatic drive(input logic v, input logic [3:0] val);
      in_valid = v;
      in_value = val;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(output int cycles);
      cycles = -1;
      for (int i = 0; i < 64; i++) begin
         if (!busy) begin
            cycles = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy, pass, fail, err_code, err_value, expected} !== 13'd0)
         $display("FAIL reset_outputs: got %b required 0",
                  {busy, pass, fail, err_code, err_value, expected});
      else n_pass++;
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      res_t got, exp;
      sb_q.push_back(res_t'({1'b1, 1'b0, 2'd0, 4'd0}));
      pulse_start();
      n_checks++;
      if ({busy, expected} !== {1'b1, 4'd0})
         $display("FAIL basic_start: busy/expected got %b/%0d required 1/0", busy, expected);
      else n_pass++;
      drive(1, 0); drive(1, 0);
      n_checks++;
      if (expected !== 4'd1) $display("FAIL basic_exp1: got %0d required 1", expected);
      else n_pass++;
      drive(1, 1); drive(1, 1);
      n_checks++;
      if (expected !== 4'd2) $display("FAIL basic_exp2: got %0d required 2", expected);
      else n_pass++;
      drive(1, 2); drive(1, 2);
      got = {pass, fail, err_code, err_value};
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp || busy !== 1'b0 || expected !== 4'd2)
         $display("FAIL basic_result: got %h busy %b exp %0d required %h busy 0 exp 2",
                  got, busy, expected, exp);
      else n_pass++;
   endtask

   task automatic test_repeat();
      res_t got, exp;
      int   cyc;
      sb_q.push_back(res_t'({1'b1, 1'b0, 2'd0, 4'd0}));
      pulse_start();
      drive(1, 0); drive(1, 0); drive(1, 0);
      drive(1, 1); drive(1, 1); drive(1, 1);
      drive(1, 2); drive(1, 2);
      wait_idle(cyc);
      got = {pass, fail, err_code, err_value};
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp || cyc !== 0)
         $display("FAIL repeat_result: got %h after %0d cycles required %h after 0", got, cyc, exp);
      else n_pass++;
   endtask

   task automatic test_unexpected();
      res_t got, exp;
      int   cyc;
      sb_q.push_back(res_t'({1'b0, 1'b1, 2'd1, 4'd3}));
      pulse_start();
      drive(1, 0); drive(1, 0); drive(1, 3);
      wait_idle(cyc);
      got = {pass, fail, err_code, err_value};
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp || cyc !== 0)
         $display("FAIL unexpected_result: got %h after %0d cycles required %h after 0",
                  got, cyc, exp);
      else n_pass++;
   endtask

   task automatic test_early_change();
      res_t got, exp;
      int   cyc;
      sb_q.push_back(res_t'({1'b0, 1'b1, 2'd3, 4'd1}));
      pulse_start();
      drive(1, 0); drive(1, 1);
      wait_idle(cyc);
      got = {pass, fail, err_code, err_value};
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp || cyc !== 0)
         $display("FAIL early_result: got %h after %0d cycles required %h after 0", got, cyc, exp);
      else n_pass++;
   endtask

   task automatic test_timeout();
      res_t got, exp;
      int   cyc;
      sb_q.push_back(res_t'({1'b0, 1'b1, 2'd2, 4'd0}));
      pulse_start();
      drive(1, 0); drive(1, 0);
      // Invalid cycles with junk on the bus; err_value must still read 0.
      cyc = -1;
      for (int i = 1; i <= 40; i++) begin
         drive(0, 4'hF);
         if (!busy) begin
            cyc = i;
            break;
         end
      end
      n_checks++;
      if (cyc !== 16) $display("FAIL timeout_cycles: got %0d required 16", cyc);
      else n_pass++;
      got = {pass, fail, err_code, err_value};
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL timeout_result: got %h required %h", got, exp);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      // Starting from DONE after a failure must clear the sticky flags.
      pulse_start();
      n_checks++;
      if ({busy, pass, fail, err_code, err_value} !== {1'b1, 8'd0})
         $display("FAIL b2b_clear: got %b required 100000000",
                  {busy, pass, fail, err_code, err_value});
      else n_pass++;
      drive(1, 0); drive(1, 0); drive(1, 1); drive(1, 1); drive(1, 2); drive(1, 2);
      pulse_start();
      n_checks++;
      if ({busy, pass, expected} !== {1'b1, 1'b0, 4'd0})
         $display("FAIL b2b_restart: got %b required 100000", {busy, pass, expected});
      else n_pass++;
      drive(1, 5);
      n_checks++;
      if ({pass, fail, err_code, err_value} !== {1'b0, 1'b1, 2'd1, 4'd5})
         $display("FAIL b2b_fail: got %b required 01010101", {pass, fail, err_code, err_value});
      else n_pass++;
   endtask

   task automatic test_bubble();
      res_t got, exp;
      int   cyc;
      sb_q.push_back(res_t'({1'b1, 1'b0, 2'd0, 4'd0}));
      pulse_start();
      drive(1, 0); drive(1, 0); drive(1, 1); drive(0, 7); drive(1, 1);
      n_checks++;
      if ({busy, expected} !== {1'b1, 4'd2})
         $display("FAIL bubble_exp: busy/expected got %b/%0d required 1/2", busy, expected);
      else n_pass++;
      drive(1, 2); drive(1, 2);
      wait_idle(cyc);
      got = {pass, fail, err_code, err_value};
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp || cyc !== 0)
         $display("FAIL bubble_result: got %h after %0d cycles required %h after 0", got, cyc, exp);
      else n_pass++;
   endtask

   task automatic test_reset_midrun();
      res_t got, exp;
      int   cyc;
      pulse_start();
      drive(1, 0); drive(1, 0); drive(1, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++;
      if ({busy, pass, fail, err_code, err_value, expected} !== 13'd0)
         $display("FAIL midrun_reset: got %b required 0",
                  {busy, pass, fail, err_code, err_value, expected});
      else n_pass++;
      // Idle after reset: valid codes alone must not start a run.
      drive(1, 0);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL midrun_idle: busy got %b required 0", busy);
      else n_pass++;
      sb_q.push_back(res_t'({1'b1, 1'b0, 2'd0, 4'd0}));
      pulse_start();
      drive(1, 0); drive(1, 0);
      pulse_start(); // ignored while busy
      n_checks++;
      if ({busy, expected} !== {1'b1, 4'd1})
         $display("FAIL midrun_start_ignored: busy/expected got %b/%0d required 1/1",
                  busy, expected);
      else n_pass++;
      drive(1, 1); drive(1, 1); drive(1, 2); drive(1, 2);
      wait_idle(cyc);
      got = {pass, fail, err_code, err_value};
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp || cyc !== 0)
         $display("FAIL midrun_result: got %h after %0d cycles required %h after 0", got, cyc, exp);
      else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_value = 4'd0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_repeat();
      test_unexpected();
      test_early_change();
      test_timeout();
      test_back_to_back();
      test_bubble();
      test_reset_midrun();
      n_checks++;
      if (sb_q.size() !== 0) $display("FAIL scoreboard_empty: got %0d entries required 0", sb_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/case_seq_monitor.md
CASE_SEQ_MONITOR -- requirements
Module: case_seq_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the width of the monitored code.
REQ-002 SHALL have parameter HOLD, default 2, the matched samples required per code (legal range 1..15).
REQ-003 SHALL have parameter LAST, default 2, the final expected code of the sequence.
REQ-004 SHALL have parameter TIMEOUT, default 16, the maximum wait cycles for the next code (legal range 1..255).
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  begins a check run when the monitor is not busy.
REQ-008 SHALL have port in_valid  input  1  qualifies in_value in the current cycle.
REQ-009 SHALL have port in_value  input  WIDTH  the decoded code from the upstream case-decode stage.
REQ-010 SHALL have port busy  output  1  high while a run is in progress.
REQ-011 SHALL have port pass  output  1  sticky: sequence 0..LAST completed.
REQ-012 SHALL have port fail  output  1  sticky: run aborted on error.
REQ-013 SHALL have port err_code  output  2  0 none, 1 unexpected value, 2 timeout, 3 early change.
REQ-014 SHALL have port err_value  output  WIDTH  the in_value captured at the failing cycle (0 for a timeout).
REQ-015 SHALL have port expected  output  WIDTH  the code currently awaited.

Function
REQ-016 SHALL implement states IDLE, WAIT, HOLD, DONE; all outputs SHALL be registered.
REQ-017 In IDLE or DONE with start=1: SHALL go to WAIT, set expected=0, clear pass, fail, err_code and err_value, clear the timeout count, and set busy=1 on the next cycle.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 In WAIT with in_valid=1 and in_value==expected: SHALL go to HOLD with hold count=1, or treat the code as completed immediately when HOLD==1.
REQ-020 In WAIT with in_valid=1, expected>0 and in_value==expected-1: SHALL stay in WAIT (previous code still held); this is not an error.
REQ-021 In WAIT with in_valid=1 and any other in_value: SHALL go to DONE with fail=1, err_code=1 and err_value=in_value.
REQ-022 In WAIT, the timeout count SHALL increment every cycle without a match; on reaching TIMEOUT, SHALL go to DONE with fail=1, err_code=2 and err_value=0.
REQ-023 In HOLD with in_valid=1 and in_value==expected: the hold count SHALL increment.
REQ-024 In HOLD with in_valid=0: the hold count SHALL freeze; this is a bubble, not an error.
REQ-025 In HOLD with in_valid=1 and in_value!=expected before the count reaches HOLD: SHALL go to DONE with fail=1, err_code=3 and err_value=in_value.
REQ-026 When the hold count reaches HOLD: if expected==LAST, SHALL go to DONE with pass=1; otherwise SHALL set expected=expected+1, clear the timeout count, and go to WAIT.
REQ-027 On entry to DONE, busy SHALL go to 0; pass, fail, err_code and err_value SHALL hold until the next start or reset.
REQ-028 pass and fail SHALL never both be 1.
REQ-029 expected SHALL never exceed LAST and SHALL not wrap.
REQ-030 If the counts reach HOLD and TIMEOUT in the same cycle, the timeout SHALL not apply (the match takes priority).
REQ-031 The hold count SHALL be 4 bits and the timeout count 8 bits; neither SHALL wrap within a run.

Reset
REQ-032 reset=1 SHALL force IDLE and clear every output to 0 (busy, pass, fail, err_code, err_value, expected) plus all internal counters, regardless of state or of start.
REQ-033 reset asserted mid-run SHALL abort the run without setting fail; the first start after reset is released SHALL begin a fresh run.

Verification (HOLD=2, LAST=2, TIMEOUT=16)
REQ-034 start, then in_value 0,0,1,1,2,2 with in_valid=1 each cycle -> pass=1 one cycle after the last 2, busy=0, fail=0.
REQ-035 start, then 0,0,0,1,1,1,2,2 -> pass=1; the extra repeats are accepted under REQ-020.
REQ-036 start, then 0,0,3 -> fail=1, err_code=1, err_value=3.
REQ-037 start, then 0,1 -> fail=1, err_code=3, err_value=1.
REQ-038 start, then 0,0 followed by in_valid=0 for 16 cycles -> fail=1, err_code=2, err_value=0; also a run with one in_valid=0 bubble in HOLD still passes.
REQ-039 reset pulsed after 0,0,1 -> all outputs 0, IDLE; then start plus the full sequence -> pass=1; start pulsed while busy -> no effect.
